dm_cache_level: RTL and testbench
=================================

Name: dm_cache_level

Overview:
Parametrised direct-mapped cache level for the multi-level hierarchy. It adds valid bits, real data return, a miss-refill FSM with a memory-side handshake, and hit/miss counters. It sits below a smaller upper-level cache, whose hit flag suppresses allocation here. It sits above a word-per-beat backing memory.

Parameters:
ADDR_W, 32, word-address width of req_addr.
INDEX_W, 9, index bits; 2^INDEX_W lines.
OFFSET_W, 4, word-offset bits; WORDS=2^OFFSET_W words per line.
DATA_W, 32, word width.
COUNT_W, 16, statistics counter width.
Derived: TAG_W = ADDR_W-INDEX_W-OFFSET_W (19 at defaults).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  lookup request.
req_ready  out  1  high only in IDLE.
req_addr  in  ADDR_W  word address: tag=[ADDR_W-1:INDEX_W+OFFSET_W], index=[INDEX_W+OFFSET_W-1:OFFSET_W], offset=[OFFSET_W-1:0].
upper_hit  in  1  upper level already hit this address; sampled with request.
resp_valid  out  1  one-cycle response strobe.
resp_hit  out  1  1=hit in this level.
resp_data  out  DATA_W  requested word.
mem_req_valid  out  1  line-fill request.
mem_req_ready  in  1  memory accepts request.
mem_req_addr  out  ADDR_W  line-aligned address {tag,index,OFFSET_W'b0}.
mem_rsp_valid  in  1  one data beat.
mem_rsp_data  in  DATA_W  beat data, words in ascending offset order.
hit_count  out  COUNT_W  saturating hit counter.
miss_count  out  COUNT_W  saturating miss counter.

Behaviour:
- Reset (async): FSM->IDLE; all valid bits=0; all outputs 0 except req_ready=1; counters=0. Tag/data arrays not reset.
- Transfer occurs when req_valid&&req_ready. addr and upper_hit are captured in that cycle (T).
- States:
  - IDLE: req_ready=1; on transfer -> LOOKUP.
  - LOOKUP (cycle T+1): hit = valid[index] && tag match.
    - hit -> RESP with resp_hit=1, resp_data=line word[offset].
    - miss && upper_hit -> RESP with resp_hit=0, resp_data=0; no allocation, no state change to the line.
    - miss && !upper_hit -> MEM_REQ; valid[index] cleared immediately.
  - MEM_REQ: mem_req_valid=1; mem_req_addr held stable until mem_req_ready; handshake -> REFILL, beat=0.
  - REFILL: each mem_rsp_valid writes word[beat] and increments beat. The beat whose number equals offset is also latched as resp_data. On beat WORDS-1: write tag, set valid=1 -> RESP with resp_hit=0.
  - RESP: resp_valid=1 for exactly one cycle, no backpressure -> IDLE.
- Latency: hit and upper_hit-miss give resp_valid at T+2. A refill miss responds one cycle after the last data beat.
- mem_rsp_valid outside REFILL is ignored. req_valid outside IDLE is ignored (req_ready=0).
- Counters update in LOOKUP only when upper_hit=0: hit -> hit_count+1, miss -> miss_count+1. They saturate at all-ones, no wrap.
- Reset mid-refill: async return to IDLE. The partial line stays invalid. Later stray beats are ignored.
- resp_hit/resp_data are held between strobes; they are meaningful only with resp_valid.

Test Plan:
- Cold miss: after reset, req_addr=0x0000_2345 (tag=1, index=0x034, offset=5), upper_hit=0 -> mem_req_addr=0x0000_2340. Memory returns 16 beats 0xA0..0xAF -> resp_valid, resp_hit=0, resp_data=0xA5; miss_count=1.
- Re-access: req_addr=0x0000_234F -> resp_valid at T+2, resp_hit=1, resp_data=0xAF; hit_count=1; no mem_req_valid.
- Conflict: req_addr=0x0000_4345 (same index, tag=2) -> refill. Then 0x0000_2345 misses again and refills; miss_count increments each time.
- Upper hit: after reset, req_addr=0x0000_0010, upper_hit=1 -> resp_hit=0 at T+2, mem_req_valid never asserts, counters unchanged. Repeat with upper_hit=0 -> refill occurs.
- Backpressure and stray beats: hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stable. Assert mem_rsp_valid while in IDLE -> no array change.
- Reset mid-refill: assert rst after beat 7 -> req_ready=1 immediately. Re-access the same address -> miss and a full refill.

Source files
------------

// File: rtl/dm_cache_level.sv
// Direct-mapped cache level. Each line holds WORDS words and has a valid bit.
// A miss that the upper level did not already service fetches the whole line
// from the backing memory one word per beat, then returns the requested word.
// Hit and miss counters saturate at all-ones.
`timescale 1ns/1ps
module dm_cache_level #(
   parameter int ADDR_W   = 32,
   parameter int INDEX_W  = 9,
   parameter int OFFSET_W = 4,
   parameter int DATA_W   = 32,
   parameter int COUNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              upper_hit,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [DATA_W-1:0] resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic [COUNT_W-1:0] hit_count,
   output logic [COUNT_W-1:0] miss_count
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES = 1 << INDEX_W;
   localparam int WORDS = 1 << OFFSET_W;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_MEM_REQ, S_REFILL, S_RESP
   } state_t;

   state_t state, state_nxt;

   // Request captured at transfer; held for the whole transaction.
   logic [ADDR_W-1:0]   addr_p0;
   logic                upper_p0;

   logic [TAG_W-1:0]    tag_p0;
   logic [INDEX_W-1:0]  index_p0;
   logic [OFFSET_W-1:0] offset_p0;

   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [DATA_W-1:0]   data_mem [LINES*WORDS];
   logic [OFFSET_W-1:0] beat;

   logic                lookup_hit;
   logic [DATA_W-1:0]   rd_word;
   logic                rsp_take;
   logic                last_beat;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign tag_p0    = addr_p0[ADDR_W-1:INDEX_W+OFFSET_W];
   assign index_p0  = addr_p0[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign offset_p0 = addr_p0[OFFSET_W-1:0];

   assign lookup_hit = valid_q[index_p0] && (tag_mem[index_p0] == tag_p0);
   assign rd_word    = data_mem[{index_p0, offset_p0}];
   assign rsp_take   = (state == S_REFILL) && mem_rsp_valid;
   assign last_beat  = rsp_take && (&beat);

   // Latch the request address and upper-level hit flag on transfer.
   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         addr_p0  <= req_addr;
         upper_p0 <= upper_hit;
      end
   end

   // Line storage: words written beat by beat, tag written with the last beat.
   always_ff @(posedge clk) begin
      if (rsp_take) begin
         data_mem[{index_p0, beat}] <= mem_rsp_data;
      end
      if (last_beat) begin
         tag_mem[index_p0] <= tag_p0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      unique case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (lookup_hit || upper_p0) state_nxt = S_RESP;
            else                        state_nxt = S_MEM_REQ;
         end
         S_MEM_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {tag_p0, index_p0, {OFFSET_W{1'b0}}};
            if (mem_req_ready) state_nxt = S_REFILL;
         end
         S_REFILL: begin
            if (last_beat) state_nxt = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Valid bits, beat counter, response registers and statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= '0;
         beat       <= '0;
         resp_hit   <= 1'b0;
         resp_data  <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         case (state)
            S_LOOKUP: begin
               if (lookup_hit) begin
                  resp_hit  <= 1'b1;
                  resp_data <= rd_word;
               end else if (upper_p0) begin
                  resp_hit  <= 1'b0;
                  resp_data <= '0;
               end else begin
                  valid_q[index_p0] <= 1'b0;
               end
               if (!upper_p0) begin
                  if (lookup_hit) hit_count  <= sat_inc(hit_count);
                  else            miss_count <= sat_inc(miss_count);
               end
            end
            S_MEM_REQ: begin
               if (mem_req_ready) beat <= '0;
            end
            S_REFILL: begin
               if (mem_rsp_valid) begin
                  beat <= beat + 1'b1;
                  if (beat == offset_p0) resp_data <= mem_rsp_data;
                  if (&beat) begin
                     valid_q[index_p0] <= 1'b1;
                     resp_hit          <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_cache_level.sv
// Bench for dm_cache_level: directed scenarios followed by random traffic,
// checked against a line-residency model of the cache and a fixed memory image.
`timescale 1ns/1ps
module tb_dm_cache_level;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        upper_hit = 1'b0;
   logic        resp_valid;
   logic        resp_hit;
   logic [31:0] resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   dm_cache_level dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .upper_hit(upper_hit),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          hit;
      logic [31:0] data;
      int          due;   // cycle of expected strobe; -1 = after last refill beat
   } exp_t;

   exp_t q[$];
   int   refill_due = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   // Reference model: which line address is resident at each index.
   bit          rv [512];
   logic [27:0] rl [512];
   int          m_hit = 0;
   int          m_miss = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:4] == 28'h0000234) return 32'hA0 + {28'h0, a[3:0]};
      return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
   endfunction

   function automatic int sat16(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      foreach (rv[i]) rv[i] = 1'b0;
      m_hit  = 0;
      m_miss = 0;
      q.delete();
   endtask

   // Monitor: every response strobe is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_hit", resp_hit, e.hit);
            chk("resp_data", resp_data, e.data);
            chk("resp_cycle", cyc, (e.due < 0) ? refill_due : e.due);
         end
      end
   end

   task automatic drain_and_count();
      int w = 0;
      while (q.size() != 0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0) begin
         chk("resp_timeout", q.size(), 0);
         q.delete();
      end
      @(negedge clk);
      chk("hit_count", hit_count, m_hit);
      chk("miss_count", miss_count, m_miss);
   endtask

   // One request; abort_at >= 0 asserts reset once that many beats were sent.
   task automatic do_req(input logic [31:0] a, input bit up, input int bp, input int abort_at);
      exp_t        e;
      int          idx;
      logic [27:0] line;
      bit          hit, refill;
      int          w;
      idx  = int'(a[12:4]);
      line = a[31:4];
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 0, 1);
         return;
      end
      hit    = rv[idx] && (rl[idx] == line);
      refill = !hit && !up;
      e.hit  = hit;
      e.data = (hit || !up) ? mem_word(a) : 32'h0;
      e.due  = refill ? -1 : cyc + 2;
      if (abort_at < 0) q.push_back(e);
      if (!up) begin
         if (hit) m_hit = sat16(m_hit);
         else     m_miss = sat16(m_miss);
      end
      if (refill) begin
         rv[idx] = (abort_at < 0);
         rl[idx] = line;
      end
      req_valid = 1'b1;
      req_addr  = a;
      upper_hit = up;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      upper_hit = 1'($urandom);
      if (refill) begin
         w = 0;
         while (!mem_req_valid && w < 10) begin
            @(negedge clk);
            w++;
         end
         if (!mem_req_valid) begin
            chk("mem_req_timeout", 0, 1);
            q.delete();
            return;
         end
         chk("mem_req_addr", mem_req_addr, {line, 4'h0});
         for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("mem_req_valid_hold", mem_req_valid, 1);
            chk("mem_req_addr_hold", mem_req_addr, {line, 4'h0});
         end
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready = 1'b0;
         for (int b = 0; b < 16; b++) begin
            if (abort_at == b) begin
               mem_rsp_valid = 1'b0;
               rst = 1'b1;
               #1;
               chk("abort_req_ready", req_ready, 1);
               chk("abort_mem_req_valid", mem_req_valid, 0);
               chk("abort_resp_valid", resp_valid, 0);
               chk("abort_miss_count", miss_count, 0);
               model_reset();
               @(negedge clk);
               rst = 1'b0;
               return;
            end
            if ($urandom_range(3) == 0) begin
               mem_rsp_valid = 1'b0;
               mem_rsp_data  = $urandom;
               @(negedge clk);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word({line, 4'(b)});
            if (b == 15) refill_due = cyc + 1;
            @(negedge clk);
         end
         mem_rsp_valid = 1'b0;
      end else begin
         repeat (2) begin
            chk("no_mem_req", mem_req_valid, 0);
            @(negedge clk);
         end
      end
      drain_and_count();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_hit", resp_hit, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_req_addr", mem_req_addr, 0);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_miss_count", miss_count, 0);
      rst = 1'b0;
      @(negedge clk);

      // Cold miss, re-access hit, conflict refills.
      do_req(32'h0000_2345, 1'b0, 0, -1);
      do_req(32'h0000_234F, 1'b0, 0, -1);
      do_req(32'h0000_4345, 1'b0, 1, -1);
      do_req(32'h0000_2345, 1'b0, 0, -1);
      do_req(32'h0000_2340, 1'b0, 0, -1);

      // Upper-level hit suppresses allocation, then a real refill with backpressure.
      do_reset();
      do_req(32'h0000_0010, 1'b1, 0, -1);
      do_req(32'h0000_0010, 1'b0, 5, -1);

      // Stray beats while idle must not disturb the stored line.
      mem_rsp_valid = 1'b1;
      repeat (4) begin
         mem_rsp_data = $urandom;
         @(negedge clk);
      end
      mem_rsp_valid = 1'b0;
      do_req(32'h0000_0013, 1'b0, 0, -1);
      do_req(32'h0000_0010, 1'b1, 0, -1);

      // Reset after eight beats, stray beats, then a full refill again.
      do_req(32'h0000_2345, 1'b0, 0, 8);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      mem_rsp_valid = 1'b0;
      do_req(32'h0000_2345, 1'b0, 2, -1);
      do_req(32'h0000_2346, 1'b0, 0, -1);

      // Random traffic over a few indices and tags to mix hits and conflicts.
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         a = {13'h0, 6'($urandom_range(3)), 9'($urandom_range(3) * 37), 4'($urandom_range(15))};
         do_req(a, ($urandom_range(3) == 0), $urandom_range(3), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
